alu_share_ctrl: RTL and testbench

Sequencer and arbiter that shares one combinational ALU between two requesters. The ALU covers add, sub, xor and compare. Each request (op, A, B) is accepted through a valid/ready handshake and registered, then driven onto the ALU for one cycle. The result is captured and returned to the originating requester through a held response handshake. The block sits between the two operand sources and the single ALU instance, and counts completed operations.

---
 rtl/alu_share_ctrl_pkg.sv | 18 +
 rtl/alu_share_ctrl_rr_arb2.sv | 33 +++
 rtl/alu_share_ctrl.sv | 125 ++++++++++++
 tb/tb_alu_share_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// rtl/alu_share_ctrl_pkg.sv - shared opcode, FSM state and compare-bit definitions
package alu_defs;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_CMP = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam int CMP_EQ = 0;
   localparam int CMP_GT = 1;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// rtl/alu_share_ctrl_rr_arb2.sv - two-way round-robin picker
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant,
   output logic       prio
);

   logic r_prio;

   assign prio = r_prio;

   // r_prio=1 means requester 1 wins a tie
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = r_prio ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_prio <= 1'b0;
      else if (advance)
         r_prio <= ~r_prio;
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - shares one external ALU between two requesters
module alu_share_ctrl
   import alu_defs::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [1:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH:0]   alu_y,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH:0]   rsp_y,
   output logic             busy,
   output logic [7:0]       op_count
);

   state_t           r_state;
   logic             r_owner;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH:0]   r_rsp_y;
   logic             r_rsp0_valid;
   logic             r_rsp1_valid;
   logic             r_busy;
   logic [7:0]       r_count;

   logic [1:0]       w_grant;
   logic             w_prio;
   logic             w_idle;
   logic             w_hs;
   logic             w_rsp_hs;

   assign w_idle   = (r_state == S_IDLE);
   assign w_hs     = w_idle & (|w_grant);
   assign w_rsp_hs = (r_rsp0_valid & rsp0_ready) | (r_rsp1_valid & rsp1_ready);

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     ({req1_valid, req0_valid}),
      .advance (w_hs),
      .grant   (w_grant),
      .prio    (w_prio)
   );

   assign req0_ready = w_idle & w_grant[0];
   assign req1_ready = w_idle & w_grant[1];

   // The latched request is the ALU drive, so alu_* only change on acceptance
   assign alu_op     = r_op;
   assign alu_a      = r_a;
   assign alu_b      = r_b;
   assign rsp0_valid = r_rsp0_valid;
   assign rsp1_valid = r_rsp1_valid;
   assign rsp_y      = r_rsp_y;
   assign busy       = r_busy;
   assign op_count   = r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_owner      <= 1'b0;
         r_op         <= 2'b00;
         r_a          <= '0;
         r_b          <= '0;
         r_rsp_y      <= '0;
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_count      <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_hs) begin
                  r_owner <= w_grant[1];
                  r_op    <= w_grant[1] ? req1_op : req0_op;
                  r_a     <= w_grant[1] ? req1_a  : req0_a;
                  r_b     <= w_grant[1] ? req1_b  : req0_b;
                  r_busy  <= 1'b1;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_rsp_y      <= alu_y;
               r_rsp0_valid <= ~r_owner;
               r_rsp1_valid <= r_owner;
               r_state      <= S_RESP;
            end
            S_RESP: begin
               if (w_rsp_hs) begin
                  r_rsp0_valid <= 1'b0;
                  r_rsp1_valid <= 1'b0;
                  r_count      <= r_count + 8'd1;
                  r_busy       <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // A tie must always resolve toward the requester holding priority
   always_ff @(posedge clk) begin
      if (!rst && w_idle && req0_valid && req1_valid)
         assert (w_grant == (w_prio ? 2'b10 : 2'b01));
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - directed self-checking bench for alu_share_ctrl
module tb_alu_share_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             req0_valid, req1_valid;
   logic             req0_ready, req1_ready;
   logic [1:0]       req0_op, req1_op;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [1:0]       alu_op;
   logic [WIDTH-1:0] alu_a, alu_b;
   logic [WIDTH:0]   alu_y;
   logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [WIDTH:0]   rsp_y;
   logic             busy;
   logic [7:0]       op_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_share_ctrl #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_y      (alu_y),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp_y      (rsp_y),
      .busy       (busy),
      .op_count   (op_count)
   );

   // behavioural ALU
   always_comb begin
      alu_y = '0;
      case (alu_op)
         2'b00:   alu_y = {1'b0, alu_a} + {1'b0, alu_b};
         2'b01:   alu_y = {(alu_a < alu_b), alu_a - alu_b};
         2'b10:   alu_y = {1'b0, alu_a ^ alu_b};
         default: alu_y = {{(WIDTH-1){1'b0}}, (alu_a > alu_b), (alu_a == alu_b)};
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int grants;
      int cyc;
      int seen;
      req0_valid = 0; req1_valid = 0;
      req0_op = 0; req0_a = 0; req0_b = 0;
      req1_op = 0; req1_a = 0; req1_b = 0;
      rsp0_ready = 0; rsp1_ready = 0;

      // reset state
      do_reset();
      #1;
      chk("rst_rsp0_valid", rsp0_valid, 0);
      chk("rst_rsp1_valid", rsp1_valid, 0);
      chk("rst_rsp_y", rsp_y, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_busy", busy, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_req0_ready_novalid", req0_ready, 0);

      // single add
      req0_valid = 1; req0_op = 2'b00; req0_a = 8'hF0; req0_b = 8'h20; rsp0_ready = 1;
      #1;
      chk("add_req0_ready", req0_ready, 1);
      chk("add_req1_ready", req1_ready, 0);
      @(negedge clk); req0_valid = 0; #1;
      chk("add_exec_busy", busy, 1);
      chk("add_exec_alu_a", alu_a, 8'hF0);
      chk("add_exec_alu_b", alu_b, 8'h20);
      chk("add_exec_rsp0", rsp0_valid, 0);
      @(negedge clk); #1;
      chk("add_rsp0_valid", rsp0_valid, 1);
      chk("add_rsp1_valid", rsp1_valid, 0);
      chk("add_rsp_y", rsp_y, 9'h110);
      @(negedge clk); #1;
      chk("add_rsp0_done", rsp0_valid, 0);
      chk("add_op_count", op_count, 1);
      chk("add_idle_busy", busy, 0);

      // contention after reset
      do_reset();
      rsp0_ready = 1; rsp1_ready = 1;
      req0_valid = 1; req0_op = 2'b10; req0_a = 8'hAA; req0_b = 8'hFF;
      req1_valid = 1; req1_op = 2'b01; req1_a = 8'h03; req1_b = 8'h05;
      #1;
      chk("cont_req0_first", req0_ready, 1);
      chk("cont_req1_wait", req1_ready, 0);
      @(negedge clk); req0_valid = 0; #1;
      chk("cont_exec_req1_ready", req1_ready, 0);
      @(negedge clk); #1;
      chk("cont_rsp0_valid", rsp0_valid, 1);
      chk("cont_rsp_y_xor", rsp_y, 9'h055);
      chk("cont_resp_req1_ready", req1_ready, 0);
      @(negedge clk); #1;
      chk("cont_req1_second", req1_ready, 1);
      @(negedge clk); req1_valid = 0;
      @(negedge clk); #1;
      chk("cont_rsp1_valid", rsp1_valid, 1);
      chk("cont_rsp0_quiet", rsp0_valid, 0);
      chk("cont_rsp_y_sub", rsp_y, 9'h1FE);
      @(negedge clk); #1;
      chk("cont_op_count", op_count, 2);
      req0_valid = 1; req1_valid = 1;
      #1;
      chk("alt_req0_again", req0_ready, 1);
      chk("alt_req1_wait", req1_ready, 0);
      @(negedge clk); req0_valid = 0; req1_valid = 0;
      @(negedge clk);
      @(negedge clk); #1;
      chk("alt_op_count", op_count, 3);

      // response stall on requester 1
      rsp1_ready = 0;
      req1_valid = 1; req1_op = 2'b11; req1_a = 8'h07; req1_b = 8'h07;
      #1;
      chk("stall_req1_ready", req1_ready, 1);
      @(negedge clk); req1_valid = 0;
      @(negedge clk);
      req0_valid = 1; req1_valid = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_rsp1_valid", rsp1_valid, 1);
         chk("stall_rsp_y", rsp_y, 9'h001);
         chk("stall_req0_ready", req0_ready, 0);
         chk("stall_req1_ready", req1_ready, 0);
         @(negedge clk);
      end
      rsp1_ready = 1; req0_valid = 0; req1_valid = 0;
      #1;
      chk("stall_release_valid", rsp1_valid, 1);
      chk("stall_count_before", op_count, 3);
      @(negedge clk); #1;
      chk("stall_done_valid", rsp1_valid, 0);
      chk("stall_count_after", op_count, 4);
      chk("stall_done_busy", busy, 0);

      // reset in EXEC (priority is with requester 1 once this add is accepted)
      req0_valid = 1; req0_op = 2'b00; req0_a = 8'h01; req0_b = 8'h02;
      #1;
      chk("mid_req0_ready", req0_ready, 1);
      @(negedge clk); req0_valid = 0; #1;
      chk("mid_exec_busy", busy, 1);
      rst = 1;
      @(negedge clk); rst = 0; #1;
      chk("mid_busy", busy, 0);
      chk("mid_op_count", op_count, 0);
      chk("mid_rsp_y", rsp_y, 0);
      req0_valid = 1; req1_valid = 1;
      #1;
      chk("mid_prio_req0", req0_ready, 1);
      chk("mid_prio_req1", req1_ready, 0);
      req0_valid = 0; req1_valid = 0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         if (rsp0_valid || rsp1_valid) seen++;
      end
      chk("mid_no_rsp", seen, 0);

      // 256 back-to-back ops from requester 0
      rsp0_ready = 1;
      req0_valid = 1; req0_op = 2'b00; req0_a = 8'hFF; req0_b = 8'h01;
      grants = 0; cyc = 0;
      while (grants < 256 && cyc < 2000) begin
         #1;
         if (req0_ready) grants++;
         @(negedge clk);
         cyc++;
      end
      req0_valid = 0;
      chk("wrap_grants", grants, 256);
      chk("wrap_cycles", cyc, 766);
      @(negedge clk); #1;
      chk("wrap_rsp_y", rsp_y, 9'h100);
      chk("wrap_count_255", op_count, 255);
      @(negedge clk); #1;
      chk("wrap_count_0", op_count, 0);
      chk("wrap_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
